gen_frame_packer: RTL and testbench



---
 rtl/gen_pkg.sv | 17 +
 rtl/gen_frame_bank.sv | 25 ++
 rtl/gen_frame_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_gen_frame_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared defaults and FSM encodings for the generator frame packer.
package gen_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int FRAME_PIXELS = 784;
  localparam int ADDR_WIDTH   = 10;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    BLOCKED = 2'd2
  } wr_state_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;
endpackage

// File: rtl/gen_frame_bank.sv
// One frame bank: single write port, single synchronous read port, no reset on contents.
module gen_frame_bank
  import gen_pkg::*;
#(
  parameter int DATA_WIDTH = gen_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = gen_pkg::ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [ADDR_WIDTH-1:0]        waddr_i,
  input  logic signed [DATA_WIDTH-1:0] wdata_i,
  input  logic                         re_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_i,
  output logic signed [DATA_WIDTH-1:0] rdata_o
);
  logic signed [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic signed [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/gen_frame_packer.sv
// Keeps the first FRAME_PIXELS samples of each generator frame, double-buffers them and
// replays each frame on a ready/valid stream. Optional drop counter: GEN_FRAME_PACKER_DROP_CNT_EN.
module gen_frame_packer
  import gen_pkg::*;
#(
  parameter int DATA_WIDTH   = gen_pkg::DATA_WIDTH,
  parameter int FRAME_PIXELS = gen_pkg::FRAME_PIXELS,
  parameter int ADDR_WIDTH   = gen_pkg::ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_clear,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_first,
  output logic                         m_last,
  output logic                         overflow,
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
  output logic [15:0]                  drop_cnt,
`endif
  output logic [15:0]                  frames_out
);
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   NPIX    = (ADDR_WIDTH + 1)'(FRAME_PIXELS);
  localparam logic [ADDR_WIDTH:0]   RD_LAST = (ADDR_WIDTH + 1)'(FRAME_PIXELS - 1);

  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            full_q, full_d, full_eff;
  logic                  overflow_q, overflow_d;
  logic                  wr_en, commit;

  rd_state_e                    rd_state_q;
  logic                         rd_bank_q;
  logic [ADDR_WIDTH:0]          rd_addr_q;
  logic                         rd_vld_q, rd_first_q, rd_last_q;
  logic                         sk_vld_q, sk_first_q, sk_last_q;
  logic signed [DATA_WIDTH-1:0] sk_data_q;
  logic                         m_valid_q, m_first_q, m_last_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic [15:0]                  frames_q;

  logic                         pop, rel, room, issue;
  logic                         load_out, out_from_sk, out_from_ram, sk_load;
  logic [1:0]                   occ;
  logic signed [DATA_WIDTH-1:0] rdata [2];
  logic signed [DATA_WIDTH-1:0] ram_rdata;

  // A release is visible to the write side in the cycle it happens.
  assign pop      = m_valid_q & m_ready;
  assign rel      = pop & m_last_q;
  assign full_eff = full_q & ~{rel & rd_bank_q, rel & ~rd_bank_q};

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    if (frame_clear) begin
      wr_cnt_d   = '0;
      wr_state_d = full_eff[wr_bank_q] ? BLOCKED : FILL;
    end else begin
      case (wr_state_q)
        FILL: begin
          if (valid_in) begin
            if (full_eff[wr_bank_q]) begin
              wr_state_d = BLOCKED;
              overflow_d = 1'b1;
            end else begin
              wr_en = 1'b1;
              if (wr_cnt_q == WR_LAST) begin
                commit     = 1'b1;
                wr_bank_d  = ~wr_bank_q;
                wr_cnt_d   = '0;
                wr_state_d = DISCARD;
              end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
              end
            end
          end
        end
        DISCARD: ;
        BLOCKED: begin
          if (valid_in) overflow_d = 1'b1;
          if (!full_eff[wr_bank_q]) begin
            wr_state_d = FILL;
            wr_cnt_d   = '0;
          end
        end
        default: wr_state_d = FILL;
      endcase
    end
  end

  always_comb begin
    full_d = full_eff;
    if (commit) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= FILL;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gen_frame_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .we_i   (wr_en && (wr_bank_q == 1'(b))),
      .waddr_i(wr_cnt_q),
      .wdata_i(data_in),
      .re_i   (issue && (rd_bank_q == 1'(b))),
      .raddr_i(rd_addr_q[ADDR_WIDTH-1:0]),
      .rdata_o(rdata[b])
    );
  end

  // Reads are issued only while RAM stage + output + skid can hold the result.
  assign ram_rdata    = rd_bank_q ? rdata[1] : rdata[0];
  assign occ          = 2'(m_valid_q) + 2'(sk_vld_q) + 2'(rd_vld_q);
  assign room         = (occ < 2'd2) | pop;
  assign issue        = room & ((rd_state_q == STREAM) ? (rd_addr_q < NPIX) : full_q[rd_bank_q]);
  assign load_out     = pop | ~m_valid_q;
  assign out_from_sk  = load_out & sk_vld_q;
  assign out_from_ram = load_out & ~sk_vld_q & rd_vld_q;
  assign sk_load      = rd_vld_q & (~load_out | sk_vld_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      sk_vld_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_first_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      frames_q   <= '0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_state_q <= STREAM;
        rd_addr_q  <= rd_addr_q + 1'b1;
        rd_first_q <= (rd_addr_q == '0);
        rd_last_q  <= (rd_addr_q == RD_LAST);
      end
      if (rel) begin
        rd_state_q <= IDLE;
        rd_bank_q  <= ~rd_bank_q;
        rd_addr_q  <= '0;
        frames_q   <= frames_q + 16'd1;
      end
      sk_vld_q <= sk_load | (sk_vld_q & ~load_out);
      if (load_out) m_valid_q <= sk_vld_q | rd_vld_q;
      if (out_from_sk) begin
        m_data_q  <= sk_data_q;
        m_first_q <= sk_first_q;
        m_last_q  <= sk_last_q;
      end else if (out_from_ram) begin
        m_data_q  <= ram_rdata;
        m_first_q <= rd_first_q;
        m_last_q  <= rd_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sk_load) begin
      sk_data_q  <= ram_rdata;
      sk_first_q <= rd_first_q;
      sk_last_q  <= rd_last_q;
    end
  end

`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = valid_in & ~frame_clear & ((wr_state_q != FILL) | full_eff[wr_bank_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (frame_clear) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_first    = m_first_q;
  assign m_last     = m_last_q;
  assign overflow   = overflow_q;
  assign frames_out = frames_q;
endmodule

// File: tb/tb_gen_frame_packer.sv
// Self-checking bench for gen_frame_packer against a frame-level reference model.
module tb_gen_frame_packer;
  localparam int FP = 784;
  typedef logic [17:0] beat_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_clear = 1'b0;
  logic               valid_in = 1'b0;
  logic signed [15:0] data_in = '0;
  logic               m_valid, m_ready = 1'b0;
  logic signed [15:0] m_data;
  logic               m_first, m_last, overflow;
  logic [15:0]        frames_out;
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
  logic [15:0]        drop_cnt;
`endif

  gen_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_clear(frame_clear),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_first    (m_first),
    .m_last     (m_last),
    .overflow   (overflow),
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .frames_out (frames_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // reference model: frames are the first FP samples after a clear, held until fully sent
  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          acc_cyc[$];
  logic [15:0] cur[$];
  int          held = 0;
  int          mode = 0;   // 0 collecting, 1 discarding flush, 2 blocked
  int          drops = 0;
  bit          ovf_m = 1'b0;

  int          rdy_mode = 0;
  int          stall_left = 0;
  bit          stall_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [18:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {13'd0, m_valid, m_first, m_last, m_data}, {13'd0, prev_out});
      if (m_valid && m_ready) begin
        got_q.push_back({m_first, m_last, m_data});
        acc_cyc.push_back(cyc);
        if (m_last) held--;
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_first, m_last, m_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && got_q.size() >= 400) begin
        stall_done = 1'b1;
        stall_left = 39;
        m_ready    = 1'b0;
      end else begin
        m_ready = ~m_ready;
      end
    end
  endtask

  task automatic send(input logic [15:0] v);
    frame_clear = 1'b0;
    valid_in    = 1'b1;
    data_in     = v;
    if (mode == 0) begin
      cur.push_back(v);
      if (cur.size() == FP) begin
        for (int i = 0; i < FP; i++) exp_q.push_back({i == 0, i == FP - 1, cur[i]});
        held++;
        cur.delete();
        mode = 1;
      end
    end else begin
      if (drops < 16'hFFFF) drops++;
      if (mode == 2) ovf_m = 1'b1;
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic clear(input bit with_sample, input logic [15:0] v);
    frame_clear = 1'b1;
    valid_in    = with_sample;
    data_in     = v;
    cur.delete();
    mode  = (held >= 2) ? 2 : 0;
    drops = 0;
    step();
    frame_clear = 1'b0;
    valid_in    = 1'b0;
  endtask

  task automatic do_reset();
    rdy_mode = 0;
    m_ready  = 1'b0;
    rst      = 1'b1;
    valid_in = 1'b0;
    frame_clear = 1'b0;
    step();
    step();
    chk("rst_state", {26'd0, m_valid, m_first, m_last, overflow, frames_out == 16'd0, m_data == 16'sd0},
        32'h3);
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); cur.delete();
    held = 0; mode = 0; drops = 0; ovf_m = 1'b0;
    stall_done = 1'b0; stall_left = 0;
    step();
  endtask

  task automatic drain(input int n);
    int budget = 20000;
    while (got_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_in_time", {31'd0, budget > 0}, 32'd1);
    repeat (8) step();
  endtask

  task automatic cmp_frames(input string tag);
    int mism = 0;
    chk({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_data"}, mism, 0);
  endtask

  initial begin
    int gap;
    int budget;

    // single frame, m_ready high, with latency check
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < FP; i++) send(16'(i));
    chk("lat_e0", {31'd0, m_valid}, 32'd0);
    send(16'hFFFF);
    chk("lat_e1", {31'd0, m_valid}, 32'd0);
    send(16'hFFFF);
    chk("lat_e2", {29'd0, m_valid, m_first, m_data == 16'sd0}, 32'h7);
    for (int i = 0; i < 298; i++) send(16'hFFFF);
    drain(FP);
    cmp_frames("single");
    chk("single_frames", {16'd0, frames_out}, exp_q.size() / FP);
    chk("single_ovf", {31'd0, overflow}, {31'd0, ovf_m});
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
    chk("single_drop_cnt", {16'd0, drop_cnt}, drops);
`endif

    // backpressure: toggling ready and one long stall
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < FP; i++) send(16'(i));
    for (int i = 0; i < 300; i++) send(16'hFFFF);
    drain(FP);
    cmp_frames("bp");
    chk("bp_frames", {16'd0, frames_out}, exp_q.size() / FP);

    // double buffering with a third frame lost
    do_reset();
    clear(1'b0, 16'd0);
    for (int i = 0; i < FP; i++) send(16'(i));
    clear(1'b0, 16'd0);
    for (int i = 0; i < FP; i++) send(16'(1000 + i));
    clear(1'b0, 16'd0);
    for (int i = 0; i < FP; i++) send(16'(2000 + i));
    chk("dbl_ovf", {31'd0, overflow}, {31'd0, ovf_m});
    chk("dbl_wait_head", {14'd0, m_valid, m_first, m_data}, {14'd0, 1'b1, 1'b1, 16'd0});
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
    chk("dbl_drop_cnt", {16'd0, drop_cnt}, drops);
`endif
    m_ready = 1'b1;
    drain(2 * FP);
    cmp_frames("dbl");
    gap = (acc_cyc.size() > FP) ? (acc_cyc[FP] - acc_cyc[FP-1] - 1) : 99;
    chk("dbl_gap_le2", {31'd0, gap <= 2}, 32'd1);
    chk("dbl_frames", {16'd0, frames_out}, exp_q.size() / FP);

    // partial frame abandoned by frame_clear
    do_reset();
    m_ready = 1'b1;
    clear(1'b0, 16'd0);
    for (int i = 0; i < 500; i++) send(16'(9000 + i));
    clear(1'b0, 16'd0);
    for (int i = 0; i < FP; i++) send(16'(5000 + i));
    for (int i = 0; i < 10; i++) send(16'hFFFF);
    drain(FP);
    cmp_frames("abort");
    chk("abort_frames", {16'd0, frames_out}, exp_q.size() / FP);

    // frame_clear coincident with a sample, random data
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < FP; i++) send(16'($urandom));
    for (int i = 0; i < 5; i++) send(16'($urandom));
    clear(1'b1, 16'd77);
`ifdef GEN_FRAME_PACKER_DROP_CNT_EN
    chk("coinc_drop_cnt", {16'd0, drop_cnt}, drops);
`endif
    for (int i = 0; i < FP; i++) send(16'($urandom));
    for (int i = 0; i < 3; i++) send(16'hFFFF);
    drain(2 * FP);
    cmp_frames("coinc");
    chk("coinc_frames", {16'd0, frames_out}, exp_q.size() / FP);

    // reset during readout, then a fresh frame with random input gaps
    do_reset();
    m_ready = 1'b1;
    clear(1'b0, 16'd0);
    for (int i = 0; i < FP; i++) begin
      send(16'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    budget = 5000;
    while (got_q.size() < 300 && budget > 0) begin
      step();
      budget--;
    end
    chk("rst_mid_reach", got_q.size(), 300);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_mid_frames", {16'd0, frames_out}, 32'd0);
    begin
      int mism = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) mism++;
      chk("rst_mid_prefix", mism, 0);
    end
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < FP; i++) begin
      send(16'($urandom));
      if ($urandom_range(0, 4) == 0) step();
    end
    for (int i = 0; i < 4; i++) send(16'($urandom));
    drain(FP);
    cmp_frames("post_rst");
    chk("post_rst_frames", {16'd0, frames_out}, exp_q.size() / FP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
